pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the architectural PC register and drives instruction fetch over the Avalon-style instruction bus. It consumes the target computed by the pcnext datapath when decode signals a control-flow redirect, implements the MIPS branch delay slot, and halts the CPU when execution reaches HALT_ADDR. It sits between the instruction memory bus and the decode/execute stage. It replaces ad-hoc PC updating in the top level.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
HALT_ADDR, 32'h00000000, PC value that stops fetch and drops active.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
instr_address  output  32  fetch address; equals pc
instr_read  output  1  fetch request; high only in FETCH
instr_waitrequest  input  1  bus stall; transfer completes on an edge where instr_read=1 and waitrequest=0
instr_readdata  input  32  fetched word; valid when the transfer completes
instr  output  32  latched instruction presented to decode
instr_valid  output  1  high while in EXEC
stall  input  1  decode/execute not ready to retire current instruction
redirect  input  1  current instruction is a taken branch/jump; sampled only in EXEC
pcnext_in  input  32  target from pcnext block; sampled with redirect
pc  output  32  address of the instruction in instr
active  output  1  high while the CPU is running
retired  output  32  count of retired instructions

Behaviour:
- States: START, FETCH, EXEC, HALT. Encoding is free.
- Reset (reset=0, asynchronous): state=START, pc=RESET_VECTOR, instr=0, delay_pending=0, delay_target=0, retired=0, active=0. Outputs during reset: instr_read=0, instr_valid=0.
- Reset mid-operation: all state returns to the reset values immediately. Any bus transfer in flight is abandoned. The next fetch is from RESET_VECTOR.
- START: on the first edge with reset=1, go to FETCH and set active=1.
- FETCH: instr_read=1, instr_address=pc. Address is held stable while waitrequest=1.
  - On an edge with waitrequest=0: instr<=instr_readdata, go to EXEC.
  - Zero-wait transfer gives 1 cycle in FETCH.
- EXEC: instr_valid=1, instr_read=0.
  - stall=1: hold all state. redirect is ignored while stalled.
  - stall=0, retire on the edge:
    - retired<=retired+1, wrapping modulo 2^32.
    - If delay_pending=1 (delay-slot instruction): pc<=delay_target, delay_pending<=0. A redirect in the delay slot is ignored.
    - Else if redirect=1: pc<=pc+4, delay_target<=pcnext_in, delay_pending<=1.
    - Else: pc<=pc+4.
  - Next state: HALT if the new pc equals HALT_ADDR, otherwise FETCH.
- HALT: active=0, instr_read=0, instr_valid=0. pc holds HALT_ADDR. The block stays here until reset.
- Arithmetic: pc+4 is a 32-bit add with wrap (32'hFFFFFFFC+4 = 0, which halts). No alignment check is performed.
- Latency: one instruction per FETCH+EXEC pair; minimum 2 cycles per instruction.
- A jump to HALT_ADDR executes its delay slot before halting.

Test Plan:
- Reset release, waitrequest=0, readdata=32'h24020005, no redirect, stall=0 -> fetches at BFC00000 then BFC00004; retired increments 1 per 2 cycles; active=1 from the first edge after release.
- waitrequest high 3 cycles during the fetch at BFC00000 -> instr_address is stable for 4 cycles, instr_valid rises the cycle after the completing edge, and instr equals the readdata sampled on that edge.
- redirect=1, pcnext_in=BFC00100 at pc=BFC00000 -> fetch order is BFC00004, then BFC00100, then BFC00104.
- redirect=1 at pc=BFC00000 (target BFC00100), then redirect=1 again at the delay slot with pcnext_in=BFC00800 -> second redirect ignored; next fetch is BFC00100.
- stall=1 for 5 cycles in EXEC with redirect toggling -> pc, instr and retired are unchanged; after stall=0 the value of redirect on the retiring edge decides the next pc.
- Jump to 00000000 at pc=BFC00010 -> the delay slot at BFC00014 is fetched and retired, then HALT with active=0, instr_read=0, and retired=2 for that sequence.
- Reset asserted while waitrequest=1 mid-fetch at BFC00008 -> outputs immediately show reset values; after release, the fetch restarts at BFC00000.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Avalon-style instruction fetch bus between the fetch sequencer and instruction memory.
interface pc_fetch_ctrl_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_waitrequest,
        input  instr_readdata
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_waitrequest,
        output instr_readdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the architectural PC, fetches over the instruction bus,
// applies MIPS branch-delay-slot redirects and halts when the PC reaches HALT_ADDR.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic               clk,
    input  logic               reset,
    pc_fetch_ctrl_if.master    bus,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        pcnext_in,
    output logic [31:0]        pc,
    output logic               active,
    output logic [31:0]        retired
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_START,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   pc_nxt;
    logic [DATA_W-1:0]   delay_target;
    logic                delay_pending;
    logic                fetch_done;
    logic                retire;

    function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] cur);
        return cur + 32'd4;
    endfunction

    assign bus.instr_address = pc;

    // A pending delay slot always wins over a fresh redirect on the retiring edge.
    always_comb begin
        pc_nxt = pc_inc(pc);
        if (delay_pending) begin
            pc_nxt = delay_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_done     = 1'b0;
        retire         = 1'b0;
        bus.instr_read = 1'b0;
        instr_valid    = 1'b0;
        active         = 1'b0;
        case (state)
            ST_START: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                bus.instr_read = 1'b1;
                active         = 1'b1;
                if (!bus.instr_waitrequest) begin
                    fetch_done = 1'b1;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                active      = 1'b1;
                if (!stall) begin
                    retire    = 1'b1;
                    state_nxt = (pc_nxt == HALT_ADDR) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_VECTOR;
            instr         <= '0;
            delay_pending <= 1'b0;
            delay_target  <= '0;
            retired       <= '0;
        end else begin
            if (fetch_done) begin
                instr <= bus.instr_readdata;
            end
            if (retire) begin
                retired <= retired + 32'd1;
                pc      <= pc_nxt;
                if (delay_pending) begin
                    delay_pending <= 1'b0;
                end else if (redirect) begin
                    delay_target  <= pcnext_in;
                    delay_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized run
// checked against an instruction-stream model of PC sequencing with delay slots.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] HA = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pcnext_in = '0;
    logic [31:0] pc;
    logic        active;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.RESET_VECTOR(RV), .HALT_ADDR(HA)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .redirect    (redirect),
        .pcnext_in   (pcnext_in),
        .pc          (pc),
        .active      (active),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in START with reset released just after an edge.
    task automatic do_reset();
        reset = 1'b0;
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata = '0;
        stall = 1'b0;
        redirect = 1'b0;
        pcnext_in = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Runs one zero-wait fetch and one unstalled retire; reports the fetch address seen.
    task automatic exec_one(input logic redir, input logic [31:0] tgt, input logic [31:0] data,
                            output logic [31:0] faddr);
        faddr = bus.instr_address;
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata = data;
        stall = 1'b0;
        redirect = 1'b0;
        tick();
        redirect = redir;
        pcnext_in = tgt;
        bus.instr_readdata = $urandom;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_waitrequest = 1'b1;
        #1;
        tests++; if (instr_read_val() !== 1'b0) begin fails++; $display("FAIL rst_read got=%b exp=0", bus.instr_read); end
        do_reset();
        tests++; if (pc !== RV) begin fails++; $display("FAIL rst_pc got=%h exp=%h", pc, RV); end
        tests++; if (bus.instr_address !== RV) begin fails++; $display("FAIL rst_addr got=%h exp=%h", bus.instr_address, RV); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr got=%h exp=0", instr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL rst_active got=%b exp=0", active); end
        tests++; if (retired !== 32'h0) begin fails++; $display("FAIL rst_retired got=%h exp=0", retired); end
    endtask

    function automatic logic instr_read_val();
        return bus.instr_read;
    endfunction

    task automatic test_sequential();
        do_reset();
        tick();
        tests++; if (active !== 1'b1) begin fails++; $display("FAIL seq_active got=%b exp=1", active); end
        tests++; if (bus.instr_read !== 1'b1 || bus.instr_address !== RV) begin fails++; $display("FAIL seq_fetch0 read=%b addr=%h exp read=1 addr=%h", bus.instr_read, bus.instr_address, RV); end
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata = 32'h24020005;
        tick();
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h24020005) begin fails++; $display("FAIL seq_exec0 valid=%b instr=%h exp valid=1 instr=24020005", instr_valid, instr); end
        tests++; if (bus.instr_read !== 1'b0 || pc !== RV || retired !== 32'd0) begin fails++; $display("FAIL seq_exec0_state read=%b pc=%h ret=%0d exp read=0 pc=%h ret=0", bus.instr_read, pc, retired, RV); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++; if (bus.instr_read !== 1'b1 || bus.instr_address !== RV + 32'(4 * k)) begin fails++; $display("FAIL seq_fetch%0d read=%b addr=%h exp read=1 addr=%h", k, bus.instr_read, bus.instr_address, RV + 32'(4 * k)); end
            tests++; if (retired !== 32'(k)) begin fails++; $display("FAIL seq_retired%0d got=%0d exp=%0d", k, retired, k); end
            tick();
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL seq_valid%0d got=%b exp=1", k, instr_valid); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        tick();
        bus.instr_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instr_readdata = 32'h11110000 + 32'(i);
            tick();
            tests++; if (bus.instr_read !== 1'b1 || bus.instr_address !== RV || instr_valid !== 1'b0) begin fails++; $display("FAIL wait_hold%0d read=%b addr=%h valid=%b exp read=1 addr=%h valid=0", i, bus.instr_read, bus.instr_address, instr_valid, RV); end
        end
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata = 32'hDEADBEEF;
        tick();
        tests++; if (instr_valid !== 1'b1 || instr !== 32'hDEADBEEF) begin fails++; $display("FAIL wait_done valid=%b instr=%h exp valid=1 instr=deadbeef", instr_valid, instr); end
        bus.instr_readdata = 32'h0BADF00D;
        stall = 1'b1;
        tick();
        tests++; if (instr !== 32'hDEADBEEF) begin fails++; $display("FAIL wait_instr_hold got=%h exp=deadbeef", instr); end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        logic [31:0] a0, a1, a2;
        do_reset();
        tick();
        exec_one(1'b1, 32'hBFC00100, 32'h10000010, a0);
        exec_one(1'b0, 32'h0, 32'h00000000, a1);
        exec_one(1'b0, 32'h0, 32'h00000000, a2);
        tests++; if (a0 !== RV) begin fails++; $display("FAIL redir_f0 got=%h exp=%h", a0, RV); end
        tests++; if (a1 !== 32'hBFC00004) begin fails++; $display("FAIL redir_f1 got=%h exp=bfc00004", a1); end
        tests++; if (a2 !== 32'hBFC00100) begin fails++; $display("FAIL redir_f2 got=%h exp=bfc00100", a2); end
        tests++; if (bus.instr_address !== 32'hBFC00104) begin fails++; $display("FAIL redir_f3 got=%h exp=bfc00104", bus.instr_address); end
    endtask

    task automatic test_delay_slot_redirect();
        logic [31:0] a0, a1, a2;
        do_reset();
        tick();
        exec_one(1'b1, 32'hBFC00100, 32'h10000010, a0);
        exec_one(1'b1, 32'hBFC00800, 32'h10000020, a1);
        tests++; if (bus.instr_address !== 32'hBFC00100) begin fails++; $display("FAIL dsr_target got=%h exp=bfc00100", bus.instr_address); end
        exec_one(1'b0, 32'h0, 32'h0, a2);
        tests++; if (bus.instr_address !== 32'hBFC00104) begin fails++; $display("FAIL dsr_after got=%h exp=bfc00104", bus.instr_address); end
        tests++; if (retired !== 32'd3) begin fails++; $display("FAIL dsr_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        do_reset();
        tick();
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata = 32'hCAFE0001;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            redirect = i[0];
            pcnext_in = 32'hBFC00200 + 32'(16 * i);
            bus.instr_readdata = $urandom;
            tick();
            tests++; if (pc !== RV || instr !== 32'hCAFE0001 || retired !== 32'd0 || instr_valid !== 1'b1) begin fails++; $display("FAIL stall_hold%0d pc=%h instr=%h ret=%0d valid=%b exp pc=%h instr=cafe0001 ret=0 valid=1", i, pc, instr, retired, instr_valid, RV); end
        end
        stall = 1'b0;
        redirect = 1'b1;
        pcnext_in = 32'hBFC00300;
        tick();
        redirect = 1'b0;
        tests++; if (bus.instr_address !== 32'hBFC00004 || retired !== 32'd1) begin fails++; $display("FAIL stall_release addr=%h ret=%0d exp addr=bfc00004 ret=1", bus.instr_address, retired); end
        exec_one(1'b0, 32'h0, 32'h0, a0);
        tests++; if (bus.instr_address !== 32'hBFC00300) begin fails++; $display("FAIL stall_target got=%h exp=bfc00300", bus.instr_address); end
    endtask

    task automatic test_halt();
        logic [31:0] a;
        logic [31:0] r0;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) exec_one(1'b0, 32'h0, 32'h0, a);
        tests++; if (bus.instr_address !== 32'hBFC00010) begin fails++; $display("FAIL halt_pre got=%h exp=bfc00010", bus.instr_address); end
        r0 = retired;
        exec_one(1'b1, HA, 32'h08000000, a);
        tests++; if (bus.instr_address !== 32'hBFC00014 || active !== 1'b1 || bus.instr_read !== 1'b1) begin fails++; $display("FAIL halt_slot addr=%h active=%b read=%b exp addr=bfc00014 active=1 read=1", bus.instr_address, active, bus.instr_read); end
        exec_one(1'b0, 32'h0, 32'h0, a);
        for (int i = 0; i < 3; i++) begin
            tests++; if (active !== 1'b0 || bus.instr_read !== 1'b0 || instr_valid !== 1'b0 || pc !== HA) begin fails++; $display("FAIL halt_state%0d active=%b read=%b valid=%b pc=%h exp 0 0 0 pc=%h", i, active, bus.instr_read, instr_valid, pc, HA); end
            tests++; if (retired !== r0 + 32'd2) begin fails++; $display("FAIL halt_retired%0d got=%0d exp=%0d", i, retired, r0 + 32'd2); end
            tick();
        end
    endtask

    task automatic test_wrap_halt();
        logic [31:0] a;
        do_reset();
        tick();
        exec_one(1'b1, 32'hFFFFFFF8, 32'h0, a);
        exec_one(1'b0, 32'h0, 32'h0, a);
        tests++; if (bus.instr_address !== 32'hFFFFFFF8) begin fails++; $display("FAIL wrap_f0 got=%h exp=fffffff8", bus.instr_address); end
        exec_one(1'b0, 32'h0, 32'h0, a);
        tests++; if (bus.instr_address !== 32'hFFFFFFFC || active !== 1'b1) begin fails++; $display("FAIL wrap_f1 addr=%h active=%b exp addr=fffffffc active=1", bus.instr_address, active); end
        exec_one(1'b0, 32'h0, 32'h0, a);
        tests++; if (active !== 1'b0 || pc !== 32'h0 || bus.instr_read !== 1'b0) begin fails++; $display("FAIL wrap_halt active=%b pc=%h read=%b exp active=0 pc=0 read=0", active, pc, bus.instr_read); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] a;
        do_reset();
        tick();
        exec_one(1'b0, 32'h0, 32'h0, a);
        exec_one(1'b0, 32'h0, 32'h0, a);
        bus.instr_waitrequest = 1'b1;
        tick();
        tests++; if (bus.instr_address !== 32'hBFC00008 || bus.instr_read !== 1'b1) begin fails++; $display("FAIL rmid_pre addr=%h read=%b exp addr=bfc00008 read=1", bus.instr_address, bus.instr_read); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (bus.instr_read !== 1'b0 || bus.instr_address !== RV || pc !== RV) begin fails++; $display("FAIL rmid_bus read=%b addr=%h pc=%h exp read=0 addr=%h", bus.instr_read, bus.instr_address, pc, RV); end
        tests++; if (active !== 1'b0 || retired !== 32'd0 || instr !== 32'h0 || instr_valid !== 1'b0) begin fails++; $display("FAIL rmid_state active=%b ret=%0d instr=%h valid=%b exp all zero", active, retired, instr, instr_valid); end
        tick();
        reset = 1'b1;
        bus.instr_waitrequest = 1'b0;
        tick();
        tests++; if (bus.instr_read !== 1'b1 || bus.instr_address !== RV || active !== 1'b1) begin fails++; $display("FAIL rmid_restart read=%b addr=%h active=%b exp read=1 addr=%h active=1", bus.instr_read, bus.instr_address, active, RV); end
    endtask

    // Model tracks the architectural instruction stream: next fetch PC, pending
    // delay-slot target and retire count, independent of the DUT's cycle structure.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] m_target;
        logic        m_pending;
        logic [31:0] m_retired;
        logic [31:0] d;
        logic        redir;
        logic [31:0] tgt;
        int          waits;
        int          stalls;
        do_reset();
        tick();
        exp_pc = RV; m_pending = 1'b0; m_target = '0; m_retired = '0;
        for (int n = 0; n < 300; n++) begin
            tests++; if (bus.instr_read !== 1'b1 || bus.instr_address !== exp_pc || active !== 1'b1) begin fails++; $display("FAIL rnd_fetch n=%0d read=%b addr=%h active=%b exp read=1 addr=%h", n, bus.instr_read, bus.instr_address, active, exp_pc); end
            waits = int'($urandom_range(0, 3));
            d = '0;
            for (int w = 0; w <= waits; w++) begin
                bus.instr_waitrequest = (w < waits);
                d = $urandom;
                bus.instr_readdata = d;
                tick();
                if (w < waits) begin
                    tests++; if (bus.instr_read !== 1'b1 || bus.instr_address !== exp_pc) begin fails++; $display("FAIL rnd_wait n=%0d read=%b addr=%h exp addr=%h", n, bus.instr_read, bus.instr_address, exp_pc); end
                end
            end
            bus.instr_waitrequest = 1'b0;
            tests++; if (instr_valid !== 1'b1 || instr !== d || pc !== exp_pc || retired !== m_retired) begin fails++; $display("FAIL rnd_exec n=%0d valid=%b instr=%h pc=%h ret=%0d exp instr=%h pc=%h ret=%0d", n, instr_valid, instr, pc, retired, d, exp_pc, m_retired); end
            stalls = int'($urandom_range(0, 2));
            for (int s = 0; s < stalls; s++) begin
                stall = 1'b1;
                redirect = $urandom_range(0, 1) != 0;
                pcnext_in = $urandom;
                tick();
                tests++; if (instr_valid !== 1'b1 || pc !== exp_pc || retired !== m_retired || instr !== d) begin fails++; $display("FAIL rnd_stall n=%0d valid=%b pc=%h ret=%0d exp pc=%h ret=%0d", n, instr_valid, pc, retired, exp_pc, m_retired); end
            end
            redir = ($urandom_range(0, 3) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? HA : ($urandom & 32'hFFFFFFFC);
            stall = 1'b0;
            redirect = redir;
            pcnext_in = tgt;
            tick();
            redirect = 1'b0;
            m_retired = m_retired + 32'd1;
            if (m_pending) begin
                exp_pc = m_target;
                m_pending = 1'b0;
            end else begin
                if (redir) begin
                    m_target = tgt;
                    m_pending = 1'b1;
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (exp_pc == HA) begin
                tests++; if (active !== 1'b0 || bus.instr_read !== 1'b0 || instr_valid !== 1'b0 || pc !== HA || retired !== m_retired) begin fails++; $display("FAIL rnd_halt n=%0d active=%b read=%b valid=%b pc=%h ret=%0d exp ret=%0d", n, active, bus.instr_read, instr_valid, pc, retired, m_retired); end
                do_reset();
                tick();
                exp_pc = RV; m_pending = 1'b0; m_target = '0; m_retired = '0;
            end
        end
    endtask

    initial begin
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata = '0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirect();
        test_delay_slot_redirect();
        test_stall();
        test_halt();
        test_wrap_halt();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
